board_ram_arbiter: RTL and testbench
====================================

// Module: board_ram_arbiter
// PURPOSE
//  Single owner of the 32x16 board RAM port. Arbitrates between the game engine (read/write)
//  and the display scanner (read-only), and runs a bulk clear sweep on request. Sits between
//  game/scanner and the board RAM; the RAM port pins drive the board RAM directly.
// PARAMETERS
//  WIDTH    32  board columns; x counts 0..WIDTH-1
//  HEIGHT   16  board rows; y counts 0..HEIGHT-1
//  RD_LAT   1   cycles from edge sampling ram_rd=1 to valid ram_out (>=1)
//  STARVE   4   max consecutive display grants while g_req waits before game is forced
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  g_req      in   1  game request; held with g_we/g_x/g_y/g_wdata stable until g_ack
//  g_we       in   1  1=write g_wdata, 0=read
//  g_x/g_y    in   5/4 game cell address
//  g_wdata    in   4  cell code to write (EMPTY=0, RIGHT=1, UP=2, LEFT=4, DOWN=8, APPLE=F)
//  g_ack      out  1  one-cycle pulse: game access done; g_rdata valid with it on reads
//  g_rdata    out  4  registered read data, held until next game read ack
//  d_req      in   1  display read request; d_x/d_y stable until d_ack
//  d_x/d_y    in   5/4 display cell address
//  d_ack      out  1  one-cycle pulse, d_rdata valid
//  d_rdata    out  4  registered display read data
//  clr_start  in   1  one-cycle pulse: clear whole board to EMPTY
//  clr_busy   out  1  high while clear pending or sweeping
//  ram_x/ram_y out 5/4 RAM address
//  ram_in     out  4  RAM write data
//  ram_rd     out  1  RAM read strobe
//  ram_wr     out  1  RAM write strobe
//  ram_out    in   4  RAM read data
//  owner      out  2  00 idle, 01 game, 10 display, 11 clear (debug/LED)
// BEHAVIOUR
//  Reset: all outputs 0 (ram_x/y/in, strobes, acks, rdata, clr_busy, owner); state IDLE;
//   starve counter 0; pending clear dropped. rst mid-access or mid-sweep aborts at once, no ack.
//  States: IDLE -> ISSUE -> WAIT (reads, RD_LAT-1 extra cycles) -> ACK -> IDLE; IDLE -> CLEAR -> IDLE.
//  IDLE: samples requests; outputs owner=00, strobes 0. Priority: pending clear > game if
//   starve count==STARVE > display > game. Winner's address/data registered onto ram_* port.
//  ISSUE (1 cycle): ram_wr=1 for game write, else ram_rd=1; owner shows winner.
//  Read: ram_out captured into requester's rdata on the edge RD_LAT after ISSUE; ack high
//   next cycle. Read latency IDLE-sample to ack = 2+RD_LAT cycles (3 at default).
//  Write: ACK directly after ISSUE; latency 2 cycles.
//  ACK (1 cycle): exactly one ack high; next cycle IDLE. Requester drops req at end of ack
//   cycle; req still high in IDLE is a new request. Strobes never high outside ISSUE/CLEAR.
//  Starve counter: +1 per display grant while g_req=1, saturating at STARVE; cleared on game grant.
//  Simultaneous g_req & d_req with counter<STARVE: display wins.
//  Clear: clr_start in any state sets pending and clr_busy=1 next cycle; in-flight access
//   completes first. CLEAR: ram_wr=1, ram_in=0 every cycle, ram_x/y from (0,0) row-major,
//   x wraps WIDTH-1->0 with y+1; WIDTH*HEIGHT=512 cycles; after (31,15) strobe drops,
//   clr_busy=0, owner=00, IDLE. clr_start during sweep ignored. Requests wait, no acks.
//  Widths: x/y arithmetic in port widths; no out-of-range address ever driven.
// TESTING
//  Game write (3,9)=1 alone -> ram_wr high 1 cycle with ram_x=3,ram_y=9,ram_in=1; g_ack 2 cycles after sample.
//  Game read (3,9) after that write -> ram_rd 1 cycle; g_ack 3 cycles after sample, g_rdata=1.
//  g_req & d_req held continuously -> grant order D,D,D,D,G,D,D,D,D,G...; no ack ever both at once.
//  clr_start after filling cells with F -> 512 consecutive ram_wr cycles (0,0)..(31,15) data 0; reads return 0.
//  clr_start while game read in flight -> g_ack then sweep; d_req during sweep acked only after clr_busy=0.
//  rst asserted in WAIT and mid-sweep -> next cycle all outputs 0, no ack, owner=00, state IDLE.

Source files
------------

// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - board RAM port arbiter: game/display access plus bulk clear sweep
module board_ram_arbiter #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 16,
   parameter int RD_LAT = 1,
   parameter int STARVE = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_g_req,
   input  logic       i_g_we,
   input  logic [4:0] i_g_x,
   input  logic [3:0] i_g_y,
   input  logic [3:0] i_g_wdata,
   output logic       o_g_ack,
   output logic [3:0] o_g_rdata,
   input  logic       i_d_req,
   input  logic [4:0] i_d_x,
   input  logic [3:0] i_d_y,
   output logic       o_d_ack,
   output logic [3:0] o_d_rdata,
   input  logic       i_clr_start,
   output logic       o_clr_busy,
   output logic [4:0] o_ram_x,
   output logic [3:0] o_ram_y,
   output logic [3:0] o_ram_in,
   output logic       o_ram_rd,
   output logic       o_ram_wr,
   input  logic [3:0] i_ram_out,
   output logic [1:0] o_owner
);

   localparam int SW = $clog2(STARVE + 1);
   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK,
      S_CLEAR
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_win_g;     // current access belongs to the game (else display)
   logic            r_we;        // current access is a game write
   logic            r_clr_pend;  // clear requested or sweeping; doubles as clr_busy
   logic [SW-1:0]   r_starve;
   logic [LW-1:0]   r_wait_cnt;
   logic [4:0]      r_ram_x;
   logic [3:0]      r_ram_y;
   logic [3:0]      r_ram_in;
   logic [3:0]      r_g_rdata;
   logic [3:0]      r_d_rdata;

   logic            w_grant_g;
   logic            w_grant_d;
   logic            w_clr_go;
   logic            w_rd_done;
   logic            w_clr_last;

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state, grant decisions and port strobes/acks decoded from the state
   always_comb begin
      w_next     = r_state;
      w_grant_g  = 1'b0;
      w_grant_d  = 1'b0;
      w_clr_go   = 1'b0;
      w_rd_done  = 1'b0;
      w_clr_last = 1'b0;
      o_ram_rd   = 1'b0;
      o_ram_wr   = 1'b0;
      o_g_ack    = 1'b0;
      o_d_ack    = 1'b0;
      o_owner    = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (r_clr_pend) begin
               w_clr_go = 1'b1;
               w_next   = S_CLEAR;
            end else if (i_g_req && (r_starve == SW'(STARVE))) begin
               w_grant_g = 1'b1;
               w_next    = S_ISSUE;
            end else if (i_d_req) begin
               w_grant_d = 1'b1;
               w_next    = S_ISSUE;
            end else if (i_g_req) begin
               w_grant_g = 1'b1;
               w_next    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_owner  = r_win_g ? 2'b01 : 2'b10;
            o_ram_wr = r_win_g && r_we;
            o_ram_rd = !(r_win_g && r_we);
            w_next   = (r_win_g && r_we) ? S_ACK : S_WAIT;
         end
         S_WAIT: begin
            o_owner = r_win_g ? 2'b01 : 2'b10;
            if (r_wait_cnt == LW'(RD_LAT - 1)) begin
               w_rd_done = 1'b1;
               w_next    = S_ACK;
            end
         end
         S_ACK: begin
            o_owner = r_win_g ? 2'b01 : 2'b10;
            o_g_ack = r_win_g;
            o_d_ack = !r_win_g;
            w_next  = S_IDLE;
         end
         S_CLEAR: begin
            o_owner  = 2'b11;
            o_ram_wr = 1'b1;
            if ((r_ram_x == 5'(WIDTH - 1)) && (r_ram_y == 4'(HEIGHT - 1))) begin
               w_clr_last = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // datapath: RAM port registers, starvation count, read capture, clear sweep address
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_win_g    <= 1'b0;
         r_we       <= 1'b0;
         r_clr_pend <= 1'b0;
         r_starve   <= '0;
         r_wait_cnt <= '0;
         r_ram_x    <= '0;
         r_ram_y    <= '0;
         r_ram_in   <= '0;
         r_g_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (w_grant_g) begin
            r_win_g  <= 1'b1;
            r_we     <= i_g_we;
            r_ram_x  <= i_g_x;
            r_ram_y  <= i_g_y;
            r_ram_in <= i_g_wdata;
            r_starve <= '0;
         end
         if (w_grant_d) begin
            r_win_g <= 1'b0;
            r_we    <= 1'b0;
            r_ram_x <= i_d_x;
            r_ram_y <= i_d_y;
            if (i_g_req && (r_starve != SW'(STARVE))) r_starve <= r_starve + 1'b1;
         end
         if (r_state == S_ISSUE) r_wait_cnt <= '0;
         else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
         if (w_rd_done) begin
            if (r_win_g) r_g_rdata <= i_ram_out;
            else         r_d_rdata <= i_ram_out;
         end
         if (i_clr_start && (r_state != S_CLEAR)) r_clr_pend <= 1'b1;
         if (w_clr_go) begin
            r_ram_x  <= '0;
            r_ram_y  <= '0;
            r_ram_in <= '0;
         end
         if ((r_state == S_CLEAR) && !w_clr_last) begin
            if (r_ram_x == 5'(WIDTH - 1)) begin
               r_ram_x <= '0;
               r_ram_y <= r_ram_y + 1'b1;
            end else begin
               r_ram_x <= r_ram_x + 1'b1;
            end
         end
         if (w_clr_last) r_clr_pend <= 1'b0;
      end
   end

   assign o_ram_x    = r_ram_x;
   assign o_ram_y    = r_ram_y;
   assign o_ram_in   = r_ram_in;
   assign o_g_rdata  = r_g_rdata;
   assign o_d_rdata  = r_d_rdata;
   assign o_clr_busy = r_clr_pend;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - self-checking bench for board_ram_arbiter
module tb_board_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       g_req = 1'b0, g_we = 1'b0;
   logic [4:0] g_x = '0;
   logic [3:0] g_y = '0, g_wdata = '0;
   logic       g_ack;
   logic [3:0] g_rdata;
   logic       d_req = 1'b0;
   logic [4:0] d_x = '0;
   logic [3:0] d_y = '0;
   logic       d_ack;
   logic [3:0] d_rdata;
   logic       clr_start = 1'b0;
   logic       clr_busy;
   logic [4:0] ram_x;
   logic [3:0] ram_y, ram_in;
   logic       ram_rd, ram_wr;
   logic [3:0] ram_out;
   logic [1:0] owner;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   logic [3:0] mem [512];
   logic [3:0] ref_board [512];

   board_ram_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_g_req(g_req), .i_g_we(g_we), .i_g_x(g_x), .i_g_y(g_y), .i_g_wdata(g_wdata),
      .o_g_ack(g_ack), .o_g_rdata(g_rdata),
      .i_d_req(d_req), .i_d_x(d_x), .i_d_y(d_y), .o_d_ack(d_ack), .o_d_rdata(d_rdata),
      .i_clr_start(clr_start), .o_clr_busy(clr_busy),
      .o_ram_x(ram_x), .o_ram_y(ram_y), .o_ram_in(ram_in),
      .o_ram_rd(ram_rd), .o_ram_wr(ram_wr), .i_ram_out(ram_out), .o_owner(owner)
   );

   always #5 clk = ~clk;

   // board RAM with one cycle read latency
   always @(posedge clk) begin
      if (ram_wr) mem[{ram_y, ram_x}] <= ram_in;
      if (ram_rd) ram_out <= mem[{ram_y, ram_x}];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one game access from the IDLE sampling cycle to the ack; n counts cycles from sampling
   task automatic game_op(input logic we, input logic [4:0] x, input logic [3:0] y,
                          input logic [3:0] wd, output logic [3:0] rd, output int lat,
                          output int nstb, output logic ok, output logic [1:0] ow);
      g_req = 1'b1; g_we = we; g_x = x; g_y = y; g_wdata = wd;
      lat = -1; nstb = 0; ok = 1'b1; rd = '0; ow = '0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (ram_wr || ram_rd) begin
            nstb++;
            ow = owner;
            if (ram_x !== x || ram_y !== y) ok = 1'b0;
            if (we && (ram_rd || ram_in !== wd)) ok = 1'b0;
            if (!we && ram_wr) ok = 1'b0;
         end
         if (g_ack) begin
            lat = n;
            rd = g_rdata;
            break;
         end
      end
      step();
      g_req = 1'b0;
   endtask

   task automatic disp_op(input logic [4:0] x, input logic [3:0] y, output logic [3:0] rd,
                          output int lat, output int nstb, output logic ok);
      d_req = 1'b1; d_x = x; d_y = y;
      lat = -1; nstb = 0; ok = 1'b1; rd = '0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (ram_wr || ram_rd) begin
            nstb++;
            if (ram_wr || ram_x !== x || ram_y !== y || owner !== 2'b10) ok = 1'b0;
         end
         if (d_ack) begin
            lat = n;
            rd = d_rdata;
            break;
         end
      end
      step();
      d_req = 1'b0;
   endtask

   initial begin
      logic [4:0] lx [4];
      logic [3:0] ly [4];
      logic [3:0] rd, wd;
      logic       ok;
      logic [1:0] ow;
      int         lat, nstb, k, op, bad, wrs, acks, cnt;
      logic       exp_g, seen_g;

      lx[0] = 5'd0;  ly[0] = 4'd0;
      lx[1] = 5'd31; ly[1] = 4'd15;
      lx[2] = 5'd3;  ly[2] = 4'd9;
      lx[3] = 5'd17; ly[3] = 4'd6;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outs", {g_ack, d_ack, ram_rd, ram_wr, clr_busy, owner, ram_x, ram_y, ram_in, g_rdata, d_rdata},
            32'd0);
      step();
      rst = 1'b0;
      step();

      // directed game write then read of (3,9)
      game_op(1'b1, 5'd3, 4'd9, 4'd1, rd, lat, nstb, ok, ow);
      ref_board[{4'd9, 5'd3}] = 4'd1;
      check("wr39_lat", lat, 2);
      check("wr39_strobes", nstb, 1);
      check("wr39_port", ok, 1);
      check("wr39_owner", ow, 2'b01);
      game_op(1'b0, 5'd3, 4'd9, 4'd0, rd, lat, nstb, ok, ow);
      check("rd39_lat", lat, 3);
      check("rd39_strobes", nstb, 1);
      check("rd39_port", ok, 1);
      check("rd39_data", rd, 4'd1);

      // seed the remaining test cells, including both board corners
      for (int i = 0; i < 4; i++) begin
         if (i != 2) begin
            wd = 4'($urandom);
            game_op(1'b1, lx[i], ly[i], wd, rd, lat, nstb, ok, ow);
            ref_board[{ly[i], lx[i]}] = wd;
            check("seed_wr_lat", lat, 2);
         end
      end

      // randomized single-requester traffic against the model board
      for (int i = 0; i < 24; i++) begin
         k = $urandom_range(0, 3);
         op = $urandom_range(0, 2);
         if (op == 0) begin
            wd = 4'($urandom);
            game_op(1'b1, lx[k], ly[k], wd, rd, lat, nstb, ok, ow);
            ref_board[{ly[k], lx[k]}] = wd;
            check("rnd_wr_lat", lat, 2);
            check("rnd_wr_port", {nstb[7:0], 7'd0, ok}, {8'd1, 8'd1});
         end else if (op == 1) begin
            game_op(1'b0, lx[k], ly[k], 4'd0, rd, lat, nstb, ok, ow);
            check("rnd_grd_lat", lat, 3);
            check("rnd_grd_data", rd, ref_board[{ly[k], lx[k]}]);
         end else begin
            disp_op(lx[k], ly[k], rd, lat, nstb, ok);
            check("rnd_drd_lat", lat, 3);
            check("rnd_drd_port", {nstb[7:0], 7'd0, ok}, {8'd1, 8'd1});
            check("rnd_drd_data", rd, ref_board[{ly[k], lx[k]}]);
         end
      end

      // both requesters held: display wins until STARVE display grants, then game
      g_req = 1'b1; g_we = 1'b0; g_x = lx[2]; g_y = ly[2];
      d_req = 1'b1; d_x = lx[3]; d_y = ly[3];
      acks = 0; cnt = 0;
      for (int n = 0; n < 400 && acks < 20; n++) begin
         @(negedge clk);
         if (g_ack && d_ack) check("both_acks", 1, 0);
         if (g_ack || d_ack) begin
            exp_g = (cnt == 4);
            cnt = exp_g ? 0 : ((cnt < 4) ? cnt + 1 : 4);
            seen_g = g_ack;
            check($sformatf("grant_%0d", acks), seen_g, exp_g);
            if (seen_g) check("cont_gdata", g_rdata, ref_board[{ly[2], lx[2]}]);
            else        check("cont_ddata", d_rdata, ref_board[{ly[3], lx[3]}]);
            acks++;
         end
      end
      check("cont_acks", acks, 20);
      step();
      g_req = 1'b0; d_req = 1'b0;
      step();

      // fill cells with APPLE, then sweep the whole board
      for (int i = 0; i < 4; i++) begin
         game_op(1'b1, lx[i], ly[i], 4'hF, rd, lat, nstb, ok, ow);
         ref_board[{ly[i], lx[i]}] = 4'hF;
      end
      game_op(1'b0, lx[1], ly[1], 4'd0, rd, lat, nstb, ok, ow);
      check("fill_rd", rd, 4'hF);
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      @(negedge clk);
      check("clr_busy_set", {clr_busy, ram_wr}, 2'b10);
      k = 0; bad = 0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (ram_wr) begin
            if (ram_x !== 5'(k % 32) || ram_y !== 4'(k / 32) || ram_in !== 4'd0 || owner !== 2'b11)
               bad++;
            k++;
         end else if (k > 0) begin
            break;
         end
      end
      for (int i = 0; i < 512; i++) ref_board[i] = 4'd0;
      check("clr_len", k, 512);
      check("clr_seq", bad, 0);
      check("clr_done", {clr_busy, owner}, 3'b000);
      step();
      for (int i = 0; i < 4; i++) begin
         disp_op(lx[i], ly[i], rd, lat, nstb, ok);
         check("clr_rdback", rd, ref_board[{ly[i], lx[i]}]);
      end

      // clear requested while a game read is in flight
      game_op(1'b1, 5'd5, 4'd5, 4'd6, rd, lat, nstb, ok, ow);
      ref_board[{4'd5, 5'd5}] = 4'd6;
      g_req = 1'b1; g_we = 1'b0; g_x = 5'd5; g_y = 4'd5;
      lat = -1; wrs = 0; rd = '0; ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (n == 1) clr_start = 1'b1;
         if (n == 2) clr_start = 1'b0;
         if (ram_wr) wrs++;
         if (g_ack) begin
            lat = n; rd = g_rdata; ok = clr_busy;
            break;
         end
      end
      check("inflt_lat", lat, 3);
      check("inflt_data", rd, 4'd6);
      check("inflt_nosweep", wrs, 0);
      check("inflt_busy", ok, 1);
      step();
      g_req = 1'b0;
      d_req = 1'b1; d_x = 5'd5; d_y = 4'd5;
      for (int i = 0; i < 512; i++) ref_board[i] = 4'd0;
      wrs = 0; ok = 1'b1; rd = 4'hA;
      for (int n = 0; n < 1200; n++) begin
         @(negedge clk);
         if (ram_wr) wrs++;
         if (d_ack) begin
            ok = clr_busy; rd = d_rdata;
            break;
         end
      end
      check("sweep_then_dack_wrs", wrs, 512);
      check("sweep_then_dack_busy", ok, 0);
      check("sweep_then_dack_data", rd, ref_board[{4'd5, 5'd5}]);
      step();
      d_req = 1'b0;
      step();

      // reset while a game read sits in WAIT
      game_op(1'b1, 5'd2, 4'd2, 4'd8, rd, lat, nstb, ok, ow);
      g_req = 1'b1; g_we = 1'b0; g_x = 5'd2; g_y = 4'd2;
      step();
      step();
      rst = 1'b1; g_req = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_wait_outs", {g_ack, d_ack, ram_rd, ram_wr, clr_busy, owner, ram_x, ram_y, ram_in, g_rdata},
            32'd0);
      acks = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (g_ack || d_ack || ram_rd || ram_wr) acks++;
      end
      check("rst_wait_quiet", acks, 0);
      step();

      // reset in the middle of a sweep
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (100) step();
      @(negedge clk);
      check("sweep_mid_active", {clr_busy, ram_wr, owner}, 4'b1111);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_sweep_outs", {g_ack, d_ack, ram_rd, ram_wr, clr_busy, owner, ram_x, ram_y, ram_in},
            32'd0);
      wrs = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ram_wr || clr_busy) wrs++;
      end
      check("rst_sweep_quiet", wrs, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
